// File: rtl/cnn_conv_acc_relu.sv
// rtl/cnn_conv_acc_relu.sv - windowed saturating accumulate, ReLU, shift and clamp of multiplier products
// One result per KERNEL_LEN accepted products; the result is held until the downstream takes it.
module cnn_conv_acc_relu #(
    parameter int PROD_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int KERNEL_LEN = 9,
    parameter int OUT_SHIFT  = 0,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic [ACC_WIDTH-1:0]  bias,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  acc_ovf,
    output logic                  busy
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(KERNEL_LEN - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] OUT_MAX  = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [OUT_WIDTH-1:0]   out_q, out_d;
    logic                   ovf_q, ovf_d;

    logic                   beat;
    logic [ACC_WIDTH-1:0]   base;
    logic [ACC_WIDTH:0]     sum;
    logic                   clamp;
    logic [ACC_WIDTH-1:0]   sat_acc;
    logic [ACC_WIDTH-1:0]   relu_acc;
    logic [ACC_WIDTH-1:0]   shifted;

    assign prod_ready = (state_q == ACCUM);
    assign out_valid  = (state_q == HOLD);
    assign out_data   = out_q;
    assign acc_ovf    = ovf_q;
    assign busy       = (count_q != '0) || (state_q == HOLD);
    assign beat       = prod_valid && prod_ready;

    // One extra bit of headroom makes overflow visible as a sign-bit disagreement.
    assign base     = (count_q == '0) ? bias : acc_q;
    assign sum      = {base[ACC_WIDTH-1], base}
                    + {{(ACC_WIDTH+1-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    assign clamp    = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
    assign sat_acc  = clamp ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
    assign relu_acc = sat_acc[ACC_WIDTH-1] ? '0 : sat_acc;
    assign shifted  = relu_acc >> OUT_SHIFT;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (beat) begin
                    acc_d = sat_acc;
                    if (clamp) begin
                        ovf_d = 1'b1;
                    end
                    if (count_q == LAST_CNT) begin
                        count_d = '0;
                        state_d = HOLD;
                        out_d   = (shifted > OUT_MAX) ? OUT_MAX[OUT_WIDTH-1:0]
                                                      : shifted[OUT_WIDTH-1:0];
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ACCUM;
            count_q <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_cnn_conv_acc_relu.sv
// tb/tb_cnn_conv_acc_relu.sv - directed bench for cnn_conv_acc_relu (default and OUT_SHIFT=2 instances)
module tb_cnn_conv_acc_relu;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [7:0]  prod_data = '0;
    logic        prod_valid = 1'b0;
    logic [15:0] bias = '0;
    logic        out_ready = 1'b1;

    logic        prod_ready, out_valid, acc_ovf, busy;
    logic [7:0]  out_data;
    logic        prod_ready2, out_valid2, acc_ovf2, busy2;
    logic [7:0]  out_data2;

    int errors = 0;
    int checks = 0;
    int prods[9];

    always #5 ap_clk = ~ap_clk;

    cnn_conv_acc_relu dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .bias(bias), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .acc_ovf(acc_ovf), .busy(busy)
    );

    cnn_conv_acc_relu #(.OUT_SHIFT(2)) dut_s2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready2),
        .bias(bias), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .acc_ovf(acc_ovf2), .busy(busy2)
    );

    // Drives n back-to-back beats from prods[]; bias is valid only on the first beat.
    task automatic send_beats(input int n, input int b);
        for (int i = 0; i < n; i++) begin
            prod_data  = 8'(prods[i]);
            bias       = (i == 0) ? 16'(b) : 16'(-1234);
            prod_valid = 1'b1;
            @(posedge ap_clk); #1;
        end
        prod_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (acc_ovf !== 1'b0) begin errors++; $display("FAIL reset_acc_ovf got=%b exp=0", acc_ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (prod_ready !== 1'b1) begin errors++; $display("FAIL reset_prod_ready got=%b exp=1", prod_ready); end
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_basic();
        int nrdy;
        int vals[9] = '{10, -3, 7, 0, 1, 2, -1, 4, 6};
        nrdy = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            prod_data  = 8'(vals[i]);
            bias       = (i == 0) ? 16'd5 : 16'(-1234);
            prod_valid = 1'b1;
            if (prod_ready !== 1'b1) nrdy++;
            if (i == 8) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
            end
            @(posedge ap_clk); #1;
        end
        prod_valid = 1'b0;
        checks++; if (nrdy != 0) begin errors++; $display("FAIL basic_prod_ready_during_accum got=%0d_low exp=0_low", nrdy); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'd31) begin errors++; $display("FAIL basic_out_data got=%0d exp=31", out_data); end
        checks++; if (prod_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready got=%b exp=0", prod_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_hold_busy got=%b exp=1", busy); end
        @(posedge ap_clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got=%b exp=0", out_valid); end
        checks++; if (prod_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got=%b exp=1", prod_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_relu();
        for (int i = 0; i < 9; i++) prods[i] = 10;
        send_beats(9, -100);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL relu_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL relu_out_data got=%0d exp=0", out_data); end
        checks++; if (acc_ovf !== 1'b0) begin errors++; $display("FAIL relu_acc_ovf got=%b exp=0", acc_ovf); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_saturate();
        prods[0] = 1;
        for (int i = 1; i < 9; i++) prods[i] = 0;
        send_beats(1, 32767);
        checks++; if (acc_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_first_beat got=%b exp=1", acc_ovf); end
        for (int i = 0; i < 8; i++) prods[i] = 0;
        send_beats(8, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'd127) begin errors++; $display("FAIL sat_out_data got=%0d exp=127", out_data); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_shift();
        prods = '{100, 50, 20, 10, 10, 5, 5, 2, 1};
        send_beats(9, 0);
        checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL shift_out_valid got=%b exp=1", out_valid2); end
        checks++; if (out_data2 !== 8'd50) begin errors++; $display("FAIL shift_out_data got=%0d exp=50", out_data2); end
        checks++; if (out_data !== 8'd127) begin errors++; $display("FAIL noshift_clamp got=%0d exp=127", out_data); end
        checks++; if (acc_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", acc_ovf); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_backpressure();
        int bad;
        for (int i = 0; i < 9; i++) prods[i] = 1;
        out_ready = 1'b0;
        send_beats(9, 3);
        prod_valid = 1'b1;
        prod_data  = 8'd2;
        bias       = 16'd100;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (prod_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd12) bad++;
            @(posedge ap_clk); #1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold_stable got=%0d_bad_cycles exp=0 data=%0d", bad, out_data); end
        checks++; if (out_data !== 8'd12) begin errors++; $display("FAIL bp_out_data got=%0d exp=12", out_data); end
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_accept_in_bubble got=%b exp=0", busy); end
        for (int i = 0; i < 9; i++) prods[i] = 2;
        send_beats(9, 100);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'd118) begin errors++; $display("FAIL bp_next_data got=%0d exp=118", out_data); end
        checks++; if (acc_ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_persist got=%b exp=1", acc_ovf); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_reset_midwindow();
        int nout;
        logic [7:0] last;
        nout = 0;
        last = '0;
        for (int i = 0; i < 4; i++) prods[i] = 5;
        send_beats(4, 7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got=%b exp=1", busy); end
        ap_rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_immediate got=%b exp=0", busy); end
        checks++; if (acc_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf_clear got=%b exp=0", acc_ovf); end
        @(posedge ap_clk); #3;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        for (int i = 0; i < 9; i++) begin
            prod_data  = 8'd1;
            bias       = (i == 0) ? 16'd0 : 16'(-1234);
            prod_valid = 1'b1;
            if (out_valid === 1'b1) begin nout++; last = out_data; end
            @(posedge ap_clk); #1;
        end
        prod_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid === 1'b1) begin nout++; last = out_data; end
            @(posedge ap_clk); #1;
        end
        checks++; if (nout != 1) begin errors++; $display("FAIL rst_output_count got=%0d exp=1", nout); end
        checks++; if (last !== 8'd9) begin errors++; $display("FAIL rst_out_data got=%0d exp=9", last); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturate();
        test_shift();
        test_backpressure();
        test_reset_midwindow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_conv_acc_relu.md
Name: cnn_conv_acc_relu

Overview:
- Streaming accumulate/activate stage directly downstream of the 8-bit signed x 2-bit unsigned weight multiplier in the CNN datapath.
- Consumes one 8-bit signed product per handshake and sums KERNEL_LEN products plus a per-output bias.
- Applies ReLU, an arithmetic right shift and saturation, then emits one 8-bit activation per window on a valid/ready output.

Parameters:
- PROD_WIDTH, 8, width of signed product input (matches multiplier dout).
- ACC_WIDTH, 16, width of signed internal accumulator and bias.
- KERNEL_LEN, 9, products per output window (legal range 1..255).
- OUT_SHIFT, 0, arithmetic right shift applied after ReLU (0..ACC_WIDTH-2).
- OUT_WIDTH, 8, width of output activation (unsigned after ReLU, range 0..2^(OUT_WIDTH-1)-1).

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- prod_data  in  PROD_WIDTH  signed product from multiplier.
- prod_valid  in  1  product valid.
- prod_ready  out  1  stage accepts a product this cycle.
- bias  in  ACC_WIDTH  signed bias; sampled on the first beat of each window.
- out_data  out  OUT_WIDTH  activation result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- acc_ovf  out  1  sticky flag: accumulator saturated at least once since reset.
- busy  out  1  high while a window is partially accumulated (count != 0) or a result is held.

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - state=ACCUM, count=0, acc=0.
  - out_valid=0, out_data=0, acc_ovf=0, busy=0.
  - prod_ready is combinational and reads 1 while in ACCUM.
  - Reset mid-window or mid-hold discards all partial and held data; no output is emitted for that window.
- States:
  - ACCUM: prod_ready=1, out_valid=0.
  - HOLD: prod_ready=0, out_valid=1, out_data stable.
- Beat accepted when prod_valid && prod_ready.
- First beat (count==0): acc <= sat(sext(bias) + sext(prod_data)).
- Later beats: acc <= sat(acc + sext(prod_data)).
- sat() clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets acc_ovf=1, which stays set until reset.
- count increments per accepted beat.
- On the beat with count==KERNEL_LEN-1:
  - count <= 0, state <= HOLD.
  - out_data <= min(relu(final_acc) >>> OUT_SHIFT, 2^(OUT_WIDTH-1)-1), where relu(x) = x<0 ? 0 : x.
  - The output is registered, so out_valid rises the cycle after the last product is accepted (latency 1).
- KERNEL_LEN==1: every accepted beat is both first and last; result = f(bias + prod).
- HOLD: on out_valid && out_ready, state <= ACCUM and out_valid <= 0 next cycle. The product is not accepted in that same cycle (one-cycle bubble per window, by design).
- out_data and out_valid hold stable while out_ready is low (no drop, no change).
- prod_valid low in ACCUM: acc and count hold. Gaps between beats are legal at any position.
- bias is ignored on all beats except count==0.
- prod_data is unused when not accepted.
- busy = (count != 0) || (state==HOLD).

Test Plan:
- KERNEL_LEN=9, OUT_SHIFT=0, bias=5, products 10,-3,7,0,1,2,-1,4,6 back-to-back, out_ready=1 -> sum 31; out_valid pulses 1 cycle after the 9th beat with out_data=31; prod_ready low for the HOLD cycle only.
- bias=-100, nine products of 10 -> sum -10 -> ReLU -> out_data=0; acc_ovf stays 0.
- bias=32767, first product 1 -> acc clamps to 32767 and acc_ovf=1; remaining products 0 -> out_data=127 (saturated). Flag persists into the next window.
- OUT_SHIFT=2, bias=0, products summing to 203 -> out_data=50.
- Backpressure: hold out_ready=0 for 5 cycles after a result while prod_valid=1 -> prod_ready=0 throughout, out_data stable. Release out_ready -> next window accepts from the following cycle, with the new bias sampled.
- Assert ap_rst_n low after 4 of 9 beats, then release and send a full window of products=1, bias=0 -> exactly one output, out_data=9. No output for the aborted window; busy=0 immediately on reset.
